// File: rtl/axi_pr_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pr_drain_pkg
// Description : Shared types and default constants for the partial-
//               reconfiguration AXI drain controller.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pr_drain_pkg;

   // Controller states: pass-through, quiescing, and safe-to-freeze.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      FROZEN = 2'd2
   } drain_state_e;

   // Default parameter values shared by the top and its counters.
   localparam int C_CNT_WIDTH      = 8;
   localparam int C_TIMEOUT_CYCLES = 4096;
   localparam int C_TIMEOUT_WIDTH  = 16;

endpackage : axi_pr_drain_pkg
`default_nettype wire

// File: rtl/axi_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// Module      : axi_outstanding_cnt
// Description : Unsigned saturating up/down counter of outstanding
//               transactions with a sticky overflow flag. Increment at the
//               maximum holds the value and raises the flag; decrement at
//               zero holds zero; simultaneous inc and dec cancel out.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_outstanding_cnt
   import axi_pr_drain_pkg::*;
#(
   parameter int WIDTH = C_CNT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_overflow
);

   localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cnt;
   logic             r_overflow;

   // Saturating count update; overflow is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= c_zero;
         r_overflow <= 1'b0;
      end else if (i_inc && !i_dec) begin
         if (r_cnt == c_max) begin
            r_overflow <= 1'b1;
         end else begin
            r_cnt <= r_cnt + c_one;
         end
      end else if (i_dec && !i_inc && (r_cnt != c_zero)) begin
         r_cnt <= r_cnt - c_one;
      end
   end

   assign o_cnt      = r_cnt;
   assign o_overflow = r_overflow;

endmodule : axi_outstanding_cnt
`default_nettype wire

// File: rtl/axi_pr_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_pr_drain_ctrl
// Description : Quiesces an AXI path ahead of partial reconfiguration.
//               Passes AW/AR through in RUN, blocks new addresses in DRAIN
//               while outstanding writes/reads/W bursts retire, then
//               acknowledges the freeze (or gives up after a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_pr_drain_ctrl
   import axi_pr_drain_pkg::*;
#(
   parameter int CNT_WIDTH      = C_CNT_WIDTH,
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
   parameter int TIMEOUT_WIDTH  = C_TIMEOUT_WIDTH
)(
   input  logic clk,
   input  logic rst,
   input  logic pr_freeze_req,
   output logic pr_freeze_ack,
   output logic drain_timeout,
   output logic cnt_overflow,
   input  logic s_awvalid,
   output logic s_awready,
   output logic m_awvalid,
   input  logic m_awready,
   input  logic s_arvalid,
   output logic s_arready,
   output logic m_arvalid,
   input  logic m_arready,
   input  logic wvalid,
   input  logic wready,
   input  logic wlast,
   input  logic bvalid,
   input  logic bready,
   input  logic rvalid,
   input  logic rready,
   input  logic rlast
);

   localparam logic signed [CNT_WIDTH:0] c_w_max  = {1'b0, {CNT_WIDTH{1'b1}}};
   localparam logic signed [CNT_WIDTH:0] c_w_min  = {1'b1, {CNT_WIDTH{1'b0}}};
   localparam logic signed [CNT_WIDTH:0] c_w_one  = {{CNT_WIDTH{1'b0}}, 1'b1};
   localparam logic signed [CNT_WIDTH:0] c_w_zero = {(CNT_WIDTH+1){1'b0}};
   localparam logic [TIMEOUT_WIDTH-1:0]  c_tmo_last =
      TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [TIMEOUT_WIDTH-1:0]  c_tmo_one  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_WIDTH-1:0]  c_tmo_max  = {TIMEOUT_WIDTH{1'b1}};
   localparam bit                        c_tmo_en   = (TIMEOUT_CYCLES > 0);

   drain_state_e               r_state;
   drain_state_e               w_state_nxt;
   logic                       r_aw_hold;
   logic                       r_ar_hold;
   logic                       r_ack;
   logic                       r_timeout;
   logic                       r_w_ovf;
   logic signed [CNT_WIDTH:0]  r_w_cnt;
   logic [TIMEOUT_WIDTH-1:0]   r_tmo_cnt;
   logic [CNT_WIDTH-1:0]       w_aw_cnt;
   logic [CNT_WIDTH-1:0]       w_ar_cnt;
   logic                       w_aw_ovf;
   logic                       w_ar_ovf;
   logic                       w_aw_pass;
   logic                       w_ar_pass;
   logic                       w_aw_hs;
   logic                       w_ar_hs;
   logic                       w_b_done;
   logic                       w_r_done;
   logic                       w_w_done;
   logic                       w_drained;
   logic                       w_tmo_hit;
   logic                       w_tmo_fire;
   logic                       w_drain_entry;

   // A channel stays transparent in RUN, and in any state while it owes a
   // stalled valid to the downstream side, so a presented valid is never
   // withdrawn.
   assign w_aw_pass = (r_state == RUN) || r_aw_hold;
   assign w_ar_pass = (r_state == RUN) || r_ar_hold;

   assign m_awvalid = w_aw_pass & s_awvalid;
   assign s_awready = w_aw_pass & m_awready;
   assign m_arvalid = w_ar_pass & s_arvalid;
   assign s_arready = w_ar_pass & m_arready;

   assign w_aw_hs  = m_awvalid & m_awready;
   assign w_ar_hs  = m_arvalid & m_arready;
   assign w_b_done = bvalid & bready;
   assign w_r_done = rvalid & rready & rlast;
   assign w_w_done = wvalid & wready & wlast;

   // Hold flags mark a downstream valid that has been presented but not
   // yet accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_hold <= 1'b0;
         r_ar_hold <= 1'b0;
      end else begin
         r_aw_hold <= m_awvalid & ~m_awready;
         r_ar_hold <= m_arvalid & ~m_arready;
      end
   end

   axi_outstanding_cnt #(
      .WIDTH      (CNT_WIDTH)
   ) u_aw_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_aw_hs),
      .i_dec      (w_b_done),
      .o_cnt      (w_aw_cnt),
      .o_overflow (w_aw_ovf)
   );

   axi_outstanding_cnt #(
      .WIDTH      (CNT_WIDTH)
   ) u_ar_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_ar_hs),
      .i_dec      (w_r_done),
      .o_cnt      (w_ar_cnt),
      .o_overflow (w_ar_ovf)
   );

   // Signed W-burst balance: W data may run ahead of its AW, going negative.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_cnt <= c_w_zero;
         r_w_ovf <= 1'b0;
      end else if (w_aw_hs && !w_w_done) begin
         if (r_w_cnt == c_w_max) begin
            r_w_ovf <= 1'b1;
         end else begin
            r_w_cnt <= r_w_cnt + c_w_one;
         end
      end else if (w_w_done && !w_aw_hs && (r_w_cnt != c_w_min)) begin
         r_w_cnt <= r_w_cnt - c_w_one;
      end
   end

   assign w_drained = (w_aw_cnt == '0) && (w_ar_cnt == '0) && (r_w_cnt == c_w_zero)
                      && !r_aw_hold && !r_ar_hold;

   assign w_tmo_hit = c_tmo_en && (r_tmo_cnt == c_tmo_last);

   // Cycles spent in DRAIN; restarts from zero whenever DRAIN is left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state != DRAIN) begin
         r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != c_tmo_max) begin
         r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an abort (request dropped) beats both exits to FROZEN.
   always_comb begin
      w_state_nxt   = r_state;
      w_tmo_fire    = 1'b0;
      w_drain_entry = 1'b0;
      case (r_state)
         RUN: begin
            if (pr_freeze_req) begin
               w_state_nxt   = DRAIN;
               w_drain_entry = 1'b1;
            end
         end
         DRAIN: begin
            if (!pr_freeze_req) begin
               w_state_nxt = RUN;
            end else if (w_drained) begin
               w_state_nxt = FROZEN;
            end else if (w_tmo_hit) begin
               w_state_nxt = FROZEN;
               w_tmo_fire  = 1'b1;
            end
         end
         FROZEN: begin
            if (!pr_freeze_req) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // Registered ack tracks FROZEN; the timeout flag lives until the next drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_ack <= (w_state_nxt == FROZEN);
         if (w_drain_entry) begin
            r_timeout <= 1'b0;
         end else if (w_tmo_fire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign pr_freeze_ack = r_ack;
   assign drain_timeout = r_timeout;
   assign cnt_overflow  = w_aw_ovf | w_ar_ovf | r_w_ovf;

endmodule : axi_pr_drain_ctrl
`default_nettype wire

// File: tb/tb_axi_pr_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_pr_drain_ctrl
// Description : Self-checking bench. Two controller instances (wide
//               counters / long timeout, and 2-bit counters / 16-cycle
//               timeout) share one stimulus and are compared each cycle
//               with a transaction-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_pr_drain_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pr_freeze_req = 0;
   logic s_awvalid = 0, m_awready = 0, s_arvalid = 0, m_arready = 0;
   logic wvalid = 0, wready = 0, wlast = 0, bvalid = 0, bready = 0;
   logic rvalid = 0, rready = 0, rlast = 0;

   logic [1:0] ack, tmo, ovf, s_awready_o, m_awvalid_o, s_arready_o, m_arvalid_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_pr_drain_ctrl #(.CNT_WIDTH(8), .TIMEOUT_CYCLES(64), .TIMEOUT_WIDTH(16)) u_dut_big (
      .clk(clk), .rst(rst), .pr_freeze_req(pr_freeze_req),
      .pr_freeze_ack(ack[0]), .drain_timeout(tmo[0]), .cnt_overflow(ovf[0]),
      .s_awvalid(s_awvalid), .s_awready(s_awready_o[0]),
      .m_awvalid(m_awvalid_o[0]), .m_awready(m_awready),
      .s_arvalid(s_arvalid), .s_arready(s_arready_o[0]),
      .m_arvalid(m_arvalid_o[0]), .m_arready(m_arready),
      .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .bvalid(bvalid), .bready(bready),
      .rvalid(rvalid), .rready(rready), .rlast(rlast));

   axi_pr_drain_ctrl #(.CNT_WIDTH(2), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(8)) u_dut_small (
      .clk(clk), .rst(rst), .pr_freeze_req(pr_freeze_req),
      .pr_freeze_ack(ack[1]), .drain_timeout(tmo[1]), .cnt_overflow(ovf[1]),
      .s_awvalid(s_awvalid), .s_awready(s_awready_o[1]),
      .m_awvalid(m_awvalid_o[1]), .m_awready(m_awready),
      .s_arvalid(s_arvalid), .s_arready(s_arready_o[1]),
      .m_arvalid(m_arvalid_o[1]), .m_arready(m_arready),
      .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .bvalid(bvalid), .bready(bready),
      .rvalid(rvalid), .rready(rready), .rlast(rlast));

   // ---------------- reference model (one slot per instance) ----------------
   localparam int M_RUN = 0, M_DRAIN = 1, M_FROZEN = 2;
   int md_mode[2], md_aw[2], md_ar[2], md_w[2], md_dc[2];
   bit md_awh[2], md_arh[2], md_ack[2], md_to[2], md_ovf[2];
   int md_cmax[2] = '{255, 3};
   int md_wmin[2] = '{-256, -4};
   int md_tlim[2] = '{64, 16};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         md_mode[i] = M_RUN; md_aw[i] = 0; md_ar[i] = 0; md_w[i] = 0; md_dc[i] = 0;
         md_awh[i] = 0; md_arh[i] = 0; md_ack[i] = 0; md_to[i] = 0; md_ovf[i] = 0;
      end
   endtask

   function automatic bit aw_open(int i);
      return (md_mode[i] == M_RUN) || md_awh[i];
   endfunction

   function automatic bit ar_open(int i);
      return (md_mode[i] == M_RUN) || md_arh[i];
   endfunction

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("m_awvalid[%0d]", i), m_awvalid_o[i], aw_open(i) & s_awvalid);
         chk($sformatf("s_awready[%0d]", i), s_awready_o[i], aw_open(i) & m_awready);
         chk($sformatf("m_arvalid[%0d]", i), m_arvalid_o[i], ar_open(i) & s_arvalid);
         chk($sformatf("s_arready[%0d]", i), s_arready_o[i], ar_open(i) & m_arready);
         chk($sformatf("ack[%0d]", i), ack[i], md_ack[i]);
         chk($sformatf("timeout[%0d]", i), tmo[i], md_to[i]);
         chk($sformatf("overflow[%0d]", i), ovf[i], md_ovf[i]);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit mav, marv, aw_hs, ar_hs, b, r, wd, drained;
         mav   = aw_open(i) & s_awvalid;
         marv  = ar_open(i) & s_arvalid;
         aw_hs = mav & m_awready;
         ar_hs = marv & m_arready;
         b     = bvalid & bready;
         r     = rvalid & rready & rlast;
         wd    = wvalid & wready & wlast;
         drained = (md_aw[i] == 0) && (md_ar[i] == 0) && (md_w[i] == 0)
                   && !md_awh[i] && !md_arh[i];
         // outstanding writes
         if (aw_hs && !b) begin
            if (md_aw[i] == md_cmax[i]) md_ovf[i] = 1; else md_aw[i]++;
         end else if (b && !aw_hs && md_aw[i] > 0) md_aw[i]--;
         // outstanding reads
         if (ar_hs && !r) begin
            if (md_ar[i] == md_cmax[i]) md_ovf[i] = 1; else md_ar[i]++;
         end else if (r && !ar_hs && md_ar[i] > 0) md_ar[i]--;
         // W balance (may go negative)
         if (aw_hs && !wd) begin
            if (md_w[i] == md_cmax[i]) md_ovf[i] = 1; else md_w[i]++;
         end else if (wd && !aw_hs && md_w[i] > md_wmin[i]) md_w[i]--;
         md_awh[i] = mav & ~m_awready;
         md_arh[i] = marv & ~m_arready;
         // mode
         if (md_mode[i] == M_RUN) begin
            if (pr_freeze_req) begin
               md_mode[i] = M_DRAIN; md_dc[i] = 0; md_to[i] = 0;
            end
         end else if (md_mode[i] == M_DRAIN) begin
            if (!pr_freeze_req) md_mode[i] = M_RUN;
            else if (drained) md_mode[i] = M_FROZEN;
            else begin
               md_dc[i]++;
               if (md_dc[i] == md_tlim[i]) begin
                  md_mode[i] = M_FROZEN; md_to[i] = 1;
               end
            end
         end else if (!pr_freeze_req) md_mode[i] = M_RUN;
         md_ack[i] = (md_mode[i] == M_FROZEN);
      end
   endtask

   // Called at a falling edge with inputs applied; returns at the next one.
   task automatic tick();
      #1;
      check_outputs();
      model_step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      s_awvalid = 0; m_awready = 0; s_arvalid = 0; m_arready = 0;
      wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
      rvalid = 0; rready = 0; rlast = 0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
      // reset state
      chk("rst_ack", ack, 2'b00);
      chk("rst_tmo", tmo, 2'b00);
      chk("rst_ovf", ovf, 2'b00);
      tick();

      // idle drain: ack on the second edge after the request
      pr_freeze_req = 1;
      tick();
      chk("idle_ack_edge1", ack, 2'b00);
      tick();
      chk("idle_ack_edge2", ack, 2'b11);
      pr_freeze_req = 0;
      tick();
      chk("idle_release", ack, 2'b00);

      // 3 writes outstanding, B returned on drain cycles 10/20/30
      s_awvalid = 1; m_awready = 1;
      repeat (3) tick();
      clear_inputs();
      wvalid = 1; wready = 1; wlast = 1;
      repeat (3) tick();
      clear_inputs();
      pr_freeze_req = 1;
      tick();
      for (int c = 1; c <= 30; c++) begin
         bvalid = (c % 10 == 0); bready = (c % 10 == 0);
         s_awvalid = (c == 5); m_awready = (c == 5);
         if (c == 5) begin
            #1;
            chk("wr_drain_blocked", s_awready_o[0], 1'b0);
         end
         tick();
      end
      clear_inputs();
      chk("wr_drain_noack", ack[0], 1'b0);
      chk("small_timed_out", tmo[1], 1'b1);
      tick();
      chk("wr_drain_ack", ack[0], 1'b1);
      chk("wr_drain_no_tmo", tmo[0], 1'b0);
      pr_freeze_req = 0;
      tick();

      // stalled AW at request time is held until accepted, then blocked
      s_awvalid = 1; m_awready = 0;
      tick();
      pr_freeze_req = 1;
      repeat (4) tick();
      chk("hold_valid_kept", m_awvalid_o[0], 1'b1);
      m_awready = 1;
      tick();
      #1;
      chk("hold_then_blocked", m_awvalid_o[0], 1'b0);
      chk("hold_then_noready", s_awready_o[0], 1'b0);
      clear_inputs();
      wvalid = 1; wready = 1; wlast = 1;
      tick();
      clear_inputs();
      bvalid = 1; bready = 1;
      tick();
      clear_inputs();
      tick();
      chk("hold_drain_ack", ack[0], 1'b1);
      pr_freeze_req = 0;
      tick();

      // unanswered read: small instance times out after 16 drain cycles
      s_arvalid = 1; m_arready = 1;
      tick();
      clear_inputs();
      pr_freeze_req = 1;
      tick();
      repeat (15) tick();
      chk("tmo_before", ack[1], 1'b0);
      tick();
      chk("tmo_ack", ack[1], 1'b1);
      chk("tmo_flag", tmo[1], 1'b1);
      chk("tmo_big_waiting", ack[0], 1'b0);
      rvalid = 1; rready = 1; rlast = 1;
      tick();
      clear_inputs();
      tick();
      chk("tmo_big_ack", ack[0], 1'b1);
      chk("tmo_big_noflag", tmo[0], 1'b0);
      pr_freeze_req = 0;
      tick();

      // abort with 2 reads outstanding
      s_arvalid = 1; m_arready = 1;
      repeat (2) tick();
      clear_inputs();
      pr_freeze_req = 1;
      repeat (2) tick();
      pr_freeze_req = 0;
      tick();
      chk("abort_noack", ack, 2'b00);
      s_arvalid = 1; m_arready = 1;
      #1;
      chk("abort_passthru", m_arvalid_o[0], 1'b1);
      tick();
      clear_inputs();
      rvalid = 1; rready = 1; rlast = 1;
      repeat (3) tick();
      clear_inputs();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         s_awvalid = 1'($urandom_range(0, 1));
         m_awready = 1'($urandom_range(0, 1));
         s_arvalid = 1'($urandom_range(0, 1));
         m_arready = 1'($urandom_range(0, 1));
         wvalid = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
         wlast = 1'($urandom_range(0, 1));
         bvalid = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1));
         rvalid = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1));
         rlast = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) pr_freeze_req = ~pr_freeze_req;
         tick();
      end
      clear_inputs();
      pr_freeze_req = 0;

      // fresh reset, then saturate the 2-bit counter and reset mid-FROZEN
      rst = 1;
      @(negedge clk);
      model_reset();
      rst = 0;
      tick();
      s_awvalid = 1; m_awready = 1;
      repeat (4) tick();
      clear_inputs();
      chk("sat_ovf_small", ovf[1], 1'b1);
      chk("sat_ovf_big", ovf[0], 1'b0);
      pr_freeze_req = 1;
      repeat (18) tick();
      chk("sat_frozen", ack[1], 1'b1);
      s_awvalid = 1;
      rst = 1;
      #1;
      chk("midrst_ack", ack, 2'b00);
      chk("midrst_tmo", tmo, 2'b00);
      chk("midrst_ovf", ovf, 2'b00);
      chk("midrst_pass", m_awvalid_o, 2'b11);
      model_reset();
      @(negedge clk);
      clear_inputs();
      pr_freeze_req = 0;
      rst = 0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_axi_pr_drain_ctrl
`default_nettype wire

// File: doc/axi_pr_drain_ctrl.md
AXI_PR_DRAIN_CTRL -- requirements
Module: axi_pr_drain_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8; width of each outstanding-transaction counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096; cycles allowed in DRAIN before forced freeze (0 = no timeout).
REQ-003 SHALL have parameter TIMEOUT_WIDTH, default 16; width of the timeout counter.
REQ-004 SHALL have ports, one clock and one asynchronous active-high reset:
  clk  in  1  block clock
  rst  in  1  async active-high reset
  pr_freeze_req  in  1  level request to quiesce the AXI path
  pr_freeze_ack  out  1  path quiesced, safe to freeze
  drain_timeout  out  1  sticky, DRAIN ended by timeout
  cnt_overflow  out  1  sticky, a counter incremented at max
  s_awvalid / s_awready  in / out  1 / 1  upstream AW handshake
  m_awvalid / m_awready  out / in  1 / 1  downstream AW handshake
  s_arvalid / s_arready  in / out  1 / 1  upstream AR handshake
  m_arvalid / m_arready  out / in  1 / 1  downstream AR handshake
  wvalid, wready, wlast  in  1 each  W channel, observe only
  bvalid, bready  in  1 each  B channel, observe only
  rvalid, rready, rlast  in  1 each  R channel, observe only

Function
REQ-005 SHALL implement states RUN, DRAIN, FROZEN.
REQ-006 RUN: m_axvalid=s_axvalid, s_axready=m_axready for AW and AR (pass-through, zero latency).
REQ-007 RUN -> DRAIN on the first cycle pr_freeze_req=1.
REQ-008 DRAIN/FROZEN: new AW/AR SHALL be blocked: m_axvalid=0 and s_axready=0, except a channel whose hold flag is set.
REQ-009 hold flag per AW/AR: set when m_axvalid=1 and m_axready=0, cleared on handshake; while set, pass-through is kept in every state so a presented valid is never withdrawn.
REQ-010 aw_cnt: +1 on m_awvalid&m_awready, -1 on bvalid&bready; simultaneous inc and dec leaves it unchanged.
REQ-011 ar_cnt: +1 on m_arvalid&m_arready, -1 on rvalid&rready&rlast; same simultaneous rule.
REQ-012 w_cnt (signed, CNT_WIDTH+1 bits): +1 on AW handshake, -1 on wvalid&wready&wlast; W may lead AW, so negative values are legal.
REQ-013 Counters SHALL saturate at max, set cnt_overflow, and never wrap; decrement at zero (aw_cnt/ar_cnt) SHALL hold zero.
REQ-014 drained = aw_cnt==0 & ar_cnt==0 & w_cnt==0 & both hold flags clear.
REQ-015 DRAIN -> FROZEN on the cycle after drained=1; pr_freeze_ack=1 registered, asserted in FROZEN only.
REQ-016 DRAIN: timeout counter increments each cycle; reaching TIMEOUT_CYCLES (nonzero) -> FROZEN and sets drain_timeout.
REQ-017 DRAIN -> RUN if pr_freeze_req drops before drained (abort); no ack pulse.
REQ-018 FROZEN -> RUN when pr_freeze_req=0; pr_freeze_ack deasserts the same edge.
REQ-019 Counters SHALL keep tracking in all states; responses arriving in FROZEN still decrement.
REQ-020 drain_timeout SHALL clear on RUN -> DRAIN entry; cnt_overflow clears only on reset.

Reset
REQ-021 rst asserted SHALL asynchronously force state RUN, all counters 0, hold flags 0, pr_freeze_ack 0, drain_timeout 0, cnt_overflow 0.
REQ-022 Reset mid-DRAIN/FROZEN SHALL return to pass-through; in-flight transaction tracking is discarded.

Structure
REQ-023 Package axi_pr_drain_pkg SHALL hold the state enum (RUN, DRAIN, FROZEN) and default parameter constants.
REQ-024 Sub-module axi_outstanding_cnt (saturating up/down counter with overflow flag) SHALL be instantiated for aw_cnt and ar_cnt.

Verification
REQ-025 Idle path, pr_freeze_req=1 -> DRAIN 1 cycle, FROZEN, pr_freeze_ack=1 on the 2nd edge after request.
REQ-026 3 AW accepted, 3 W bursts, req=1, B returned on cycles 10/20/30 -> ack one cycle after 3rd B; new s_awvalid sees s_awready=0.
REQ-027 m_awvalid=1 & m_awready=0 when req rises -> m_awvalid held until ready, then counted, and blocked afterwards.
REQ-028 1 AR outstanding never answered, TIMEOUT_CYCLES=16 -> FROZEN after 16 DRAIN cycles, drain_timeout=1, ack=1.
REQ-029 req drops in DRAIN with 2 outstanding -> RUN, ack stays 0, pass-through restored next cycle.
REQ-030 CNT_WIDTH=2, 4 AW without B -> aw_cnt saturates at 3, cnt_overflow=1; rst mid-FROZEN -> all outputs at reset values.
